// File: rtl/conv_wload_if.sv
// Handshake and memory-side bundle between the layer controller, conv_wload,
// the weight memory and the weight-register chain.
interface conv_wload_if #(
  parameter int unsigned WADDR = 16
);
  logic             start;
  logic [WADDR-1:0] base_addr;
  logic             mem_re;
  logic [WADDR-1:0] mem_addr;
  logic             wreg_we;
  logic             busy;
  logic             done;

  modport master (
    output start, base_addr,
    input  mem_re, mem_addr, wreg_we, busy, done
  );

  modport slave (
    input  start, base_addr,
    output mem_re, mem_addr, wreg_we, busy, done
  );
endinterface

// File: rtl/conv_wload.sv
// Weight-fetch sequencer: reads FSIZE*FSIZE consecutive weight words and
// issues one chain shift-enable per word, aligned with the memory read data.
module conv_wload #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned WADDR  = 16,
  parameter int unsigned FSIZE  = 5
) (
  input logic         clk,
  input logic         xrst,
  conv_wload_if.slave bus
);
  localparam int unsigned TAPS  = FSIZE * FSIZE;
  localparam int unsigned CNT_W = $clog2(TAPS);

  // Read data flows memory -> chain outside this block; width only sanity-checked.
  if (DWIDTH == 0) begin : g_bad_dwidth
    $error("conv_wload: DWIDTH must be non-zero");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WADDR-1:0] r_addr;
  logic             r_re;
  logic             r_we;
  logic             r_busy;
  logic             r_done;

  // First FETCH edge raises mem_re at base; later edges advance address/count.
  // DRAIN also accepts start so continuous loads repeat every 27 cycles.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= r_re;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_cnt  <= '0;
          if (bus.start) begin
            r_state <= S_FETCH;
            r_addr  <= bus.base_addr;
          end
        end
        S_FETCH: begin
          r_busy <= 1'b1;
          if (r_re && (r_cnt == CNT_W'(TAPS - 1))) begin
            r_state <= S_DRAIN;
            r_re    <= 1'b0;
          end else begin
            r_re <= 1'b1;
            if (r_re) begin
              r_addr <= r_addr + WADDR'(1);
              r_cnt  <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
          if (bus.start) begin
            r_state <= S_FETCH;
            r_addr  <= bus.base_addr;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_re   = r_re;
  assign bus.mem_addr = r_addr;
  assign bus.wreg_we  = r_we;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_conv_wload.sv
// Directed bench for conv_wload with a synchronous weight memory and a
// serial weight-chain model driven by the DUT outputs.
module tb_conv_wload;
  localparam int unsigned TAPS = 25;

  logic clk;
  logic xrst;
  int   n_assert;
  int   n_fail;

  conv_wload_if #(.WADDR(16)) bus ();

  conv_wload #(.DWIDTH(16), .WADDR(16), .FSIZE(5)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  logic [15:0] rdata;
  logic [15:0] wchain [TAPS];

  always @(posedge clk) if (bus.mem_re) rdata <= mem[bus.mem_addr];

  // Data enters at the far end, so the first word fetched ends in weight 0.
  always @(posedge clk) begin
    if (bus.wreg_we) begin
      for (int i = 0; i < TAPS - 1; i++) wchain[i] <= wchain[i + 1];
      wchain[TAPS - 1] <= rdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered in cycle 0 (start already sampled). Checks cycles 1..27 and the chain.
  // busy_cyc: cycle in which a stray start is driven; chain_base: start again in cycle 26.
  task automatic load_body(input logic [15:0] base, input int busy_cyc,
                           input bit chain, input logic [15:0] chain_base);
    int n_we;
    int n_done;
    n_we   = 0;
    n_done = 0;
    for (int n = 1; n <= 27; n++) begin
      bus.start     = 1'b0;
      bus.base_addr = 16'h0000;
      if (n == busy_cyc + 1) begin
        bus.start     = 1'b1;
        bus.base_addr = 16'h0200;
      end
      if (chain && n == 27) begin
        bus.start     = 1'b1;
        bus.base_addr = chain_base;
      end
      step();
      chk($sformatf("mem_re c%0d", n), 32'(bus.mem_re), 32'(n <= 25));
      if (n <= 25) chk($sformatf("mem_addr c%0d", n), 32'(bus.mem_addr), 32'(16'(base + 16'(n - 1))));
      chk($sformatf("wreg_we c%0d", n), 32'(bus.wreg_we), 32'(n >= 2 && n <= 26));
      chk($sformatf("busy c%0d", n), 32'(bus.busy), 32'(n <= 26));
      chk($sformatf("done c%0d", n), 32'(bus.done), 32'(n == 27));
      n_we   += int'(bus.wreg_we);
      n_done += int'(bus.done);
    end
    chk("we_pulses", 32'(n_we), 32'(TAPS));
    chk("done_pulses", 32'(n_done), 32'd1);
    for (int k = 0; k < TAPS; k++)
      chk($sformatf("weight%0d", k), 32'(wchain[k]), 32'(mem[16'(base + 16'(k))]));
  endtask

  task automatic kick(input logic [15:0] base);
    bus.start     = 1'b1;
    bus.base_addr = base;
    step();
    bus.start     = 1'b0;
    bus.base_addr = 16'h0000;
  endtask

  int n_we_r, n_re_r, n_done_r, n_viol;
  logic prev_re;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a * 3 + 7);
    for (int k = 0; k < TAPS; k++) mem[16'h0100 + k] = 16'(k + 1);

    xrst          = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = 16'h0000;
    step();
    step();
    chk("rst mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst wreg_we", 32'(bus.wreg_we), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    xrst = 1'b1;
    step();

    // Basic load, weight k = k+1
    kick(16'h0100);
    load_body(16'h0100, -10, 1'b0, 16'h0000);
    chk("basic w0", 32'(wchain[0]), 32'd1);
    chk("basic w24", 32'(wchain[24]), 32'd25);
    step();
    chk("idle addr hold", 32'(bus.mem_addr), 32'h0118);

    // Address wrap past 0xFFFF
    kick(16'hFFF0);
    load_body(16'hFFF0, -10, 1'b0, 16'h0000);
    chk("wrap w15", 32'(wchain[15]), 32'(16'(16'hFFFF * 3 + 7)));
    chk("wrap w16", 32'(wchain[16]), 32'h0007);
    step();

    // Start while busy is ignored
    kick(16'h0100);
    load_body(16'h0100, 10, 1'b0, 16'h0000);
    step();
    chk("stray start idle", 32'(bus.busy), 32'd0);

    // Back-to-back: second start accepted in the done cycle
    kick(16'h0100);
    load_body(16'h0100, -10, 1'b1, 16'h0300);
    load_body(16'h0300, -10, 1'b0, 16'h0000);
    step();

    // Reset during cycle 10 of a load
    kick(16'h0100);
    for (int n = 1; n <= 10; n++) step();
    chk("pre-rst busy", 32'(bus.busy), 32'd1);
    xrst = 1'b0;
    #1;
    chk("mid-rst mem_re", 32'(bus.mem_re), 32'd0);
    chk("mid-rst wreg_we", 32'(bus.wreg_we), 32'd0);
    chk("mid-rst busy", 32'(bus.busy), 32'd0);
    chk("mid-rst done", 32'(bus.done), 32'd0);
    chk("mid-rst mem_addr", 32'(bus.mem_addr), 32'd0);
    step();
    xrst = 1'b1;
    step();
    chk("post-rst idle", 32'(bus.mem_re), 32'd0);
    kick(16'h0400);
    load_body(16'h0400, -10, 1'b0, 16'h0000);
    step();

    // Random starts: pulse accounting
    n_we_r   = 0;
    n_re_r   = 0;
    n_done_r = 0;
    n_viol   = 0;
    prev_re  = bus.mem_re;
    for (int c = 0; c < 1030; c++) begin
      bus.start     = (c < 1000) && ($urandom_range(0, 7) == 0);
      bus.base_addr = 16'($urandom);
      step();
      if (bus.wreg_we && !prev_re) n_viol++;
      n_we_r   += int'(bus.wreg_we);
      n_re_r   += int'(bus.mem_re);
      n_done_r += int'(bus.done);
      prev_re   = bus.mem_re;
    end
    chk("rand done>0", 32'(n_done_r > 10), 32'd1);
    chk("rand we=25*done", 32'(n_we_r), 32'(TAPS * n_done_r));
    chk("rand re=25*done", 32'(n_re_r), 32'(TAPS * n_done_r));
    chk("rand we after re", 32'(n_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
